rom_boot_loader: RTL

Copies a boot image out of the synchronous boot ROM into main RAM, holding the 8080 core off the bus until the copy is complete. Sits directly downstream of the ROM: it drives the ROM's address/read-enable and consumes its one-cycle-latency data. It also drives a simple RAM write port with a ready handshake. Used for turnkey boot (e.g. loader image to 0xFF00) and for re-loading on request from the front panel.

---
 rtl/altair_boot_pkg.sv | 15 +
 rtl/rom_boot_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/altair_boot_pkg.sv
// Shared definitions for the boot-ROM copy engine.
//   boot_state_e      : copy FSM states
//   DEST_BASE_DEFAULT : RAM address the turnkey loader image lands at
package altair_boot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } boot_state_e;

    localparam logic [15:0] DEST_BASE_DEFAULT = 16'hFF00;

endpackage

// File: rtl/rom_boot_loader.sv
// Copies COUNT bytes from the synchronous boot ROM into main RAM at DEST_BASE while holding the
// CPU off the bus. One byte takes a READ cycle (address to ROM) followed by one or more WRITE
// cycles (ROM data presented to RAM until ram_ready accepts it).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   copy request, sampled only in IDLE/DONE
//   rom_addr   out  ROM read address
//   rom_rd     out  ROM read enable
//   rom_data   in   ROM data, valid the cycle after rom_rd
//   ram_addr   out  RAM write address
//   ram_data   out  RAM write data
//   ram_we     out  RAM write request
//   ram_ready  in   RAM accepts a write when ram_we & ram_ready
//   busy       out  copy in progress
//   done       out  copy finished, held until next start or reset
//   cpu_hold   out  keep the CPU in reset/wait
//   checksum   out  modulo-2^DATA_WIDTH sum of bytes written this run
module rom_boot_loader
    import altair_boot_pkg::*;
#(
    parameter int unsigned                   ROM_ADDR_WIDTH = 8,
    parameter int unsigned                   RAM_ADDR_WIDTH = 16,
    parameter int unsigned                   DATA_WIDTH     = 8,
    parameter int unsigned                   COUNT          = 256,
    parameter logic [RAM_ADDR_WIDTH-1:0]     DEST_BASE      = RAM_ADDR_WIDTH'(DEST_BASE_DEFAULT),
    parameter bit                            AUTO_START     = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    output logic                      rom_rd,
    input  logic [DATA_WIDTH-1:0]     rom_data,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_data,
    output logic                      ram_we,
    input  logic                      ram_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      cpu_hold,
    output logic [DATA_WIDTH-1:0]     checksum
);

    // One extra bit so COUNT == 2**ROM_ADDR_WIDTH can be represented without wrapping.
    localparam int unsigned       IDX_W    = ROM_ADDR_WIDTH + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(COUNT - 1);

    boot_state_e               state_q, state_d;
    logic [IDX_W-1:0]          index_q, index_d;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]     checksum_q, checksum_d;
    logic                      done_q, done_d;
    logic                      auto_pending_q, auto_pending_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            index_q        <= '0;
            rom_addr_q     <= '0;
            ram_addr_q     <= DEST_BASE;
            checksum_q     <= '0;
            done_q         <= 1'b0;
            auto_pending_q <= AUTO_START;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            rom_addr_q     <= rom_addr_d;
            ram_addr_q     <= ram_addr_d;
            checksum_q     <= checksum_d;
            done_q         <= done_d;
            auto_pending_q <= auto_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        rom_addr_d     = rom_addr_q;
        ram_addr_d     = ram_addr_q;
        checksum_d     = checksum_q;
        done_d         = done_q;
        auto_pending_d = auto_pending_q;

        unique case (state_q)
            IDLE, DONE: begin
                // A start coinciding with a pending auto-start still yields a single run.
                if (start || auto_pending_q) begin
                    state_d        = READ;
                    index_d        = '0;
                    rom_addr_d     = '0;
                    checksum_d     = '0;
                    done_d         = 1'b0;
                    auto_pending_d = 1'b0;
                end
            end
            READ: begin
                state_d    = WRITE;
                // Destination wraps at the top of the RAM address space.
                ram_addr_d = DEST_BASE + RAM_ADDR_WIDTH'(index_q);
            end
            WRITE: begin
                if (ram_ready) begin
                    checksum_d = checksum_q + rom_data;
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = READ;
                        index_d    = index_q + IDX_W'(1);
                        rom_addr_d = ROM_ADDR_WIDTH'(index_q + IDX_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State decodes; ram_we follows the async-reset state register so it drops immediately.
    assign rom_rd   = (state_q == READ);
    assign ram_we   = (state_q == WRITE);
    assign busy     = (state_q == READ) || (state_q == WRITE);
    assign cpu_hold = busy || ((state_q == IDLE) && auto_pending_q);

    assign rom_addr = rom_addr_q;
    assign ram_addr = ram_addr_q;
    // ROM output is held while rom_rd is low, so it is stable for the whole WRITE phase.
    assign ram_data = rom_data;
    assign done     = done_q;
    assign checksum = checksum_q;

endmodule
